dlx_ifetch_prefetch: RTL and testbench

//  Instruction-fetch front end of the DLX that masters the read-only memory port
//  (ADDRESS/ENABLE out, DATA_READY/DATA in), one request in flight at a time.

---
 rtl/dlx_ifetch_prefetch_if.sv | 27 ++
 rtl/dlx_ifetch_prefetch.sv | 165 ++++++++++++++++
 tb/tb_dlx_ifetch_prefetch.sv | 336 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dlx_ifetch_prefetch_if.sv
// Memory read port and decode handshake of the DLX instruction-fetch front end.
// master = fetch unit, slave = memory/decode side.
interface dlx_ifetch_prefetch_if #(
    parameter int ADDRESS_SIZE = 16,
    parameter int WORD_SIZE    = 32
);
    // Memory: once ENABLE=1, ENABLE/ADDRESS hold until the single-cycle DATA_READY strobe.
    // Decode: a word transfers on a rising clk edge where instr_valid_o && instr_ready_i.
    logic [ADDRESS_SIZE-1:0] ADDRESS;
    logic                    ENABLE;
    logic                    DATA_READY;
    logic [WORD_SIZE-1:0]    DATA;
    logic [WORD_SIZE-1:0]    instr_o;
    logic [ADDRESS_SIZE-1:0] instr_pc_o;
    logic                    instr_valid_o;
    logic                    instr_ready_i;

    modport master (
        output ADDRESS, ENABLE, instr_o, instr_pc_o, instr_valid_o,
        input  DATA_READY, DATA, instr_ready_i
    );

    modport slave (
        input  ADDRESS, ENABLE, instr_o, instr_pc_o, instr_valid_o,
        output DATA_READY, DATA, instr_ready_i
    );
endinterface

// File: rtl/dlx_ifetch_prefetch.sv
// DLX instruction prefetch: one outstanding memory read, DEPTH-entry FIFO to decode, redirect flush.
// Define IFETCH_PERF_CNT_EN to add the stall_cnt_o / discard_cnt_o performance counters.
module dlx_ifetch_prefetch #(
    parameter int                      ADDRESS_SIZE = 16,
    parameter int                      WORD_SIZE    = 32,
    parameter int                      DEPTH        = 4,
    parameter logic [ADDRESS_SIZE-1:0] RESET_PC     = '0
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    fetch_en_i,
    input  logic                    redirect_i,
    input  logic [ADDRESS_SIZE-1:0] redirect_addr_i,
    output logic [1:0]              fsm_state,
`ifdef IFETCH_PERF_CNT_EN
    output logic [31:0]             stall_cnt_o,
    output logic [31:0]             discard_cnt_o,
`endif
    dlx_ifetch_prefetch_if.master   bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0]        CNT_DEPTH = CNT_W'(DEPTH);
    localparam logic [ADDRESS_SIZE-1:0] PC_STEP   = ADDRESS_SIZE'(WORD_SIZE / 8);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t                  state_q, state_d;
    logic                    enable_q, enable_d;
    logic [ADDRESS_SIZE-1:0] address_q, address_d;
    logic [ADDRESS_SIZE-1:0] pc_q, pc_d;

    logic [WORD_SIZE-1:0]    data_mem [DEPTH];
    logic [ADDRESS_SIZE-1:0] pc_mem   [DEPTH];
    logic [PTR_W-1:0]        rd_ptr_q, wr_ptr_q;
    logic [CNT_W-1:0]        count_q, count_after;

    logic resp, push, pop, valid;

    assign resp        = enable_q && bus.DATA_READY;
    assign valid       = (count_q != '0);
    assign pop         = valid && bus.instr_ready_i;
    // Occupancy after a push plus any same-cycle pop; used for the back-to-back space check.
    assign count_after = count_q + CNT_W'(1) - CNT_W'(pop);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            enable_q  <= 1'b0;
            address_q <= '0;
            pc_q      <= RESET_PC;
        end else begin
            state_q   <= state_d;
            enable_q  <= enable_d;
            address_q <= address_d;
            pc_q      <= pc_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        enable_d  = enable_q;
        address_d = address_q;
        pc_d      = pc_q;
        push      = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (fetch_en_i && (count_q < CNT_DEPTH) && !redirect_i) begin
                    enable_d  = 1'b1;
                    address_d = pc_q;
                    state_d   = REQ;
                end
            end
            REQ: begin
                if (redirect_i) begin
                    if (resp) begin
                        enable_d = 1'b0;
                        state_d  = IDLE;
                    end else begin
                        state_d  = DRAIN;
                    end
                end else if (resp) begin
                    push = 1'b1;
                    pc_d = pc_q + PC_STEP;
                    if (fetch_en_i && (count_after < CNT_DEPTH)) begin
                        address_d = pc_q + PC_STEP;
                    end else begin
                        enable_d = 1'b0;
                        state_d  = IDLE;
                    end
                end
            end
            DRAIN: begin
                if (resp) begin
                    enable_d = 1'b0;
                    state_d  = IDLE;
                end
            end
            default: begin
                enable_d = 1'b0;
                state_d  = IDLE;
            end
        endcase
        // A redirect overrides any sequential PC update in the same cycle.
        if (redirect_i) begin
            pc_d = redirect_addr_i;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                data_mem[i] <= '0;
                pc_mem[i]   <= '0;
            end
        end else if (redirect_i) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                data_mem[wr_ptr_q] <= bus.DATA;
                pc_mem[wr_ptr_q]   <= address_q;
                wr_ptr_q           <= wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            count_q <= count_q + CNT_W'(push) - CNT_W'(pop);
        end
    end

    assign bus.ENABLE        = enable_q;
    assign bus.ADDRESS       = address_q;
    assign bus.instr_o       = data_mem[rd_ptr_q];
    assign bus.instr_pc_o    = pc_mem[rd_ptr_q];
    assign bus.instr_valid_o = valid;
    assign fsm_state         = state_q;

`ifdef IFETCH_PERF_CNT_EN
    logic discard;
    assign discard = resp && ((state_q == DRAIN) || ((state_q == REQ) && redirect_i));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cnt_o   <= '0;
            discard_cnt_o <= '0;
        end else begin
            if (enable_q && !bus.DATA_READY && (stall_cnt_o != '1)) begin
                stall_cnt_o <= stall_cnt_o + 32'd1;
            end
            if (discard && (discard_cnt_o != '1)) begin
                discard_cnt_o <= discard_cnt_o + 32'd1;
            end
        end
    end
`endif
endmodule

// File: tb/tb_dlx_ifetch_prefetch.sv
// Bench for dlx_ifetch_prefetch: memory responder, decode consumer and an in-order scoreboard.
module tb_dlx_ifetch_prefetch;
    localparam int AW    = 16;
    localparam int WW    = 32;
    localparam int DEPTH = 4;
    localparam int EW    = WW + AW;

    logic          clk = 1'b0;
    logic          rst;
    logic          fetch_en;
    logic          redirect;
    logic [AW-1:0] redirect_addr;
    logic [1:0]    fsm_state;
`ifdef IFETCH_PERF_CNT_EN
    logic [31:0]   stall_cnt;
    logic [31:0]   discard_cnt;
`endif

    dlx_ifetch_prefetch_if #(.ADDRESS_SIZE(AW), .WORD_SIZE(WW)) bus ();

    dlx_ifetch_prefetch #(
        .ADDRESS_SIZE(AW),
        .WORD_SIZE   (WW),
        .DEPTH       (DEPTH),
        .RESET_PC    (16'h0000)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .fetch_en_i     (fetch_en),
        .redirect_i     (redirect),
        .redirect_addr_i(redirect_addr),
        .fsm_state      (fsm_state),
`ifdef IFETCH_PERF_CNT_EN
        .stall_cnt_o    (stall_cnt),
        .discard_cnt_o  (discard_cnt),
`endif
        .bus            (bus.master)
    );

    always #5 clk = ~clk;

    // Scoreboard entries are {data, pc}.
    logic [EW-1:0] exp_q[$];
    int            n_cmp = 0;
    int            n_err = 0;

    logic          outstanding;
    logic          drop_pending;
    logic [AW-1:0] held_addr;
    logic [AW-1:0] exp_issue_pc;
    int            wait_cnt;
    int            cur_lat;
    int            lat;
    logic          rand_lat;
    int            issue_cnt;
    int            n_dropped;
    int            stall_seen;
    logic          watch_on;
    int            watch_n;
    logic [AW-1:0] watch_pc [2];

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic bench_reset();
        exp_q.delete();
        outstanding     = 1'b0;
        drop_pending    = 1'b0;
        held_addr       = '0;
        exp_issue_pc    = 16'h0000;
        wait_cnt        = 0;
        cur_lat         = 0;
        n_dropped       = 0;
        stall_seen      = 0;
        bus.DATA_READY  = 1'b0;
        bus.DATA        = '0;
    endtask

    task automatic watch_start();
        watch_on    = 1'b1;
        watch_n     = 0;
        watch_pc[0] = 16'hFFFF;
        watch_pc[1] = 16'hFFFF;
    endtask

    // Bench view of what the coming rising edge does; inputs and outputs are stable here.
    task automatic model_edge();
        logic          resp;
        logic          pop;
        logic [EW-1:0] e;
        resp = bus.ENABLE && bus.DATA_READY;
        pop  = bus.instr_valid_o && bus.instr_ready_i;
        check_eq("instr_valid", bus.instr_valid_o, exp_q.size() != 0);
        if (bus.ENABLE && !bus.DATA_READY) stall_seen++;
        if (pop && !redirect) begin
            if (exp_q.size() == 0) begin
                check_eq("pop_unexpected", bus.instr_valid_o, 1'b0);
            end else begin
                e = exp_q.pop_front();
                check_eq("instr_pc", bus.instr_pc_o, e[AW-1:0]);
                check_eq("instr", bus.instr_o, e[EW-1:AW]);
                if (watch_on && watch_n < 2) begin
                    watch_pc[watch_n] = bus.instr_pc_o;
                    watch_n++;
                end
            end
        end
        if (redirect) begin
            exp_q.delete();
            exp_issue_pc = redirect_addr;
            if (resp) begin
                outstanding  = 1'b0;
                drop_pending = 1'b0;
                n_dropped++;
            end else if (outstanding) begin
                drop_pending = 1'b1;
            end
        end else if (resp) begin
            outstanding = 1'b0;
            if (drop_pending) begin
                drop_pending = 1'b0;
                n_dropped++;
            end else begin
                exp_q.push_back({bus.DATA, held_addr});
                exp_issue_pc = held_addr + 16'd4;
            end
        end
    endtask

    // Memory responder, run just after each falling edge.
    task automatic mem_drive();
        bus.DATA_READY = 1'b0;
        if (bus.ENABLE) begin
            if (!outstanding) begin
                check_eq("issue_addr", bus.ADDRESS, exp_issue_pc);
                check_eq("issue_space", exp_q.size() < DEPTH, 1'b1);
                outstanding = 1'b1;
                held_addr   = bus.ADDRESS;
                wait_cnt    = 0;
                cur_lat     = rand_lat ? int'($urandom_range(0, 3)) : lat;
                issue_cnt++;
            end else begin
                check_eq("hold_addr", bus.ADDRESS, held_addr);
            end
            if (wait_cnt >= cur_lat) begin
                bus.DATA_READY = 1'b1;
                bus.DATA       = $urandom;
            end else begin
                wait_cnt++;
            end
        end else if (outstanding) begin
            check_eq("hold_enable", bus.ENABLE, 1'b1);
        end
    endtask

    task automatic tick();
        model_edge();
        @(posedge clk);
        @(negedge clk);
        mem_drive();
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic do_redirect(input logic [AW-1:0] addr);
        redirect      = 1'b1;
        redirect_addr = addr;
        tick();
        redirect      = 1'b0;
    endtask

    initial begin
        int   base;
        int   tmp;
        logic found;

        rst               = 1'b0;
        fetch_en          = 1'b0;
        redirect          = 1'b0;
        redirect_addr     = '0;
        bus.instr_ready_i = 1'b0;
        lat               = 2;
        rand_lat          = 1'b0;
        issue_cnt         = 0;
        watch_on          = 1'b0;
        watch_n           = 0;
        bench_reset();
        repeat (2) @(negedge clk);

        // Reset state
        check_eq("rst_enable", bus.ENABLE, 1'b0);
        check_eq("rst_address", bus.ADDRESS, 16'h0);
        check_eq("rst_valid", bus.instr_valid_o, 1'b0);
        check_eq("rst_instr", bus.instr_o, 32'h0);
        check_eq("rst_instr_pc", bus.instr_pc_o, 16'h0);
        check_eq("rst_state", fsm_state, 2'd0);
`ifdef IFETCH_PERF_CNT_EN
        check_eq("rst_stall_cnt", stall_cnt, 32'h0);
        check_eq("rst_discard_cnt", discard_cnt, 32'h0);
`endif

        // Sequential fetch, two-cycle memory
        rst               = 1'b1;
        fetch_en          = 1'b1;
        bus.instr_ready_i = 1'b1;
        watch_start();
        run(40);
        check_eq("t1_first_pc", watch_pc[0], 16'h0000);
        check_eq("t1_second_pc", watch_pc[1], 16'h0004);

        // Fill with decode stalled, then release exactly one word
        bus.instr_ready_i = 1'b0;
        lat               = 0;
        do_redirect(16'h0000);
        base = issue_cnt;
        run(15);
        check_eq("t2_issued", issue_cnt - base, 4);
        check_eq("t2_enable_off", bus.ENABLE, 1'b0);
        if (!bus.ENABLE) bus.DATA_READY = 1'b1;
        tick();
        bus.instr_ready_i = 1'b1;
        tick();
        bus.instr_ready_i = 1'b0;
        run(10);
        check_eq("t2_issued_after_pop", issue_cnt - base, 5);
        check_eq("t2_enable_off2", bus.ENABLE, 1'b0);
        bus.instr_ready_i = 1'b1;
        run(10);

        // Redirect while a slow request at 0x8 is pending
        lat = 4;
        do_redirect(16'h0000);
        found = 1'b0;
        for (int i = 0; i < 60; i++) begin
            if (bus.ENABLE && bus.ADDRESS == 16'h0008 && wait_cnt == 1) begin
                found = 1'b1;
                break;
            end
            tick();
        end
        check_eq("t3_found_req", found, 1'b1);
        do_redirect(16'h0100);
        check_eq("t3_flushed", bus.instr_valid_o, 1'b0);
        watch_start();
        run(30);
        check_eq("t3_first_pc", watch_pc[0], 16'h0100);

        // Redirect coinciding with DATA_READY
        lat               = 2;
        bus.instr_ready_i = 1'b0;
        run(8);
        found = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (bus.DATA_READY) begin
                found = 1'b1;
                break;
            end
            tick();
        end
        check_eq("t4_found_resp", found, 1'b1);
        do_redirect(16'h0200);
        check_eq("t4_flushed", bus.instr_valid_o, 1'b0);
        bus.instr_ready_i = 1'b1;
        watch_start();
        run(20);
        check_eq("t4_first_pc", watch_pc[0], 16'h0200);

        // PC wrap at the top of the address space
        lat = 1;
        do_redirect(16'hFFFC);
        watch_start();
        run(20);
        check_eq("t5_pc_top", watch_pc[0], 16'hFFFC);
        check_eq("t5_pc_wrap", watch_pc[1], 16'h0000);

        // Asynchronous reset in the middle of a request
        lat   = 3;
        found = 1'b0;
        for (int i = 0; i < 30; i++) begin
            if (bus.ENABLE && !bus.DATA_READY) begin
                found = 1'b1;
                break;
            end
            tick();
        end
        check_eq("t6_found_req", found, 1'b1);
        rst = 1'b0;
        #1;
        check_eq("t6_enable", bus.ENABLE, 1'b0);
        check_eq("t6_valid", bus.instr_valid_o, 1'b0);
`ifdef IFETCH_PERF_CNT_EN
        check_eq("t6_stall_cnt", stall_cnt, 32'h0);
        check_eq("t6_discard_cnt", discard_cnt, 32'h0);
`endif
        bench_reset();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        watch_start();
        run(20);
        check_eq("t6_first_pc", watch_pc[0], 16'h0000);

        // Randomised traffic with occasional redirects
        rand_lat = 1'b1;
        for (int i = 0; i < 400; i++) begin
            fetch_en          = ($urandom_range(0, 7) != 0);
            bus.instr_ready_i = ($urandom_range(0, 3) != 0);
            tmp               = int'($urandom_range(0, 16'h3FFF));
            redirect_addr     = AW'(tmp << 2);
            redirect          = ($urandom_range(0, 24) == 0);
            tick();
        end
        redirect          = 1'b0;
        fetch_en          = 1'b0;
        bus.instr_ready_i = 1'b1;
        rand_lat          = 1'b0;
        lat               = 1;
        run(20);
        check_eq("final_valid", bus.instr_valid_o, 1'b0);
        check_eq("final_enable", bus.ENABLE, 1'b0);
`ifdef IFETCH_PERF_CNT_EN
        check_eq("final_stall_cnt", stall_cnt, stall_seen);
        check_eq("final_discard_cnt", discard_cnt, n_dropped);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
